// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master, one-slave pipelined Wishbone arbiter with STALL.
//
// Bus ownership is granted per bus cycle. The owner keeps the slave port for
// as long as it holds CYC and is never preempted. When the owner drops CYC the
// port passes straight to the other master if it is requesting. Otherwise the
// arbiter returns to idle. The only state is the owner select and a
// last-owner bit. Every master-to-slave and slave-to-master path is a
// combinational mux steered by that registered select.
//
// Optional feature:
//   WB_ARB_ROUND_ROBIN_EN - when defined, a simultaneous request in IDLE goes
//                           to the master that did not own the bus last.
//                           When undefined, m0 always wins the tie.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m0_* / m1_*  (in)            master cyc, stb, we, sel, adr, dat
//   m0_* / m1_*  (out)           stall, ack, read data (broadcast, ack-qualified)
//   s_*          (out)           slave cyc, stb, we, sel, adr, dat
//   s_stall_i, s_ack_i, s_dat_i  slave responses
//   grant_o                      one-hot current owner (bit0 = m0), 00 when idle
module wb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic                m0_stall_o,
  output logic                m0_ack_o,
  output logic [DATA_W-1:0]   m0_dat_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic                m1_stall_o,
  output logic                m1_ack_o,
  output logic [DATA_W-1:0]   m1_dat_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic                s_stall_i,
  input  logic                s_ack_i,
  input  logic [DATA_W-1:0]   s_dat_i,

  output logic [1:0]          grant_o
);

  // The encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state;
  logic   last_owner;
  logic   tie_to_m1;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // The tie goes to whichever master did not own the bus last.
  assign tie_to_m1 = ~last_owner;
`else
  // Fixed priority. The ownership history is still tracked, but it is masked here.
  assign tie_to_m1 = last_owner & 1'b0;
`endif

  // Owner-select register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= tie_to_m1 ? GRANT1 : GRANT0;
          else if (m0_cyc_i)        state <= GRANT0;
          else if (m1_cyc_i)        state <= GRANT1;
        end
        GRANT0: begin
          if (!m0_cyc_i) begin
            last_owner <= 1'b0;
            state      <= m1_cyc_i ? GRANT1 : IDLE;
          end
        end
        GRANT1: begin
          if (!m1_cyc_i) begin
            last_owner <= 1'b1;
            state      <= m0_cyc_i ? GRANT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_o = state;

  // Combinational bus mux steered by the registered owner
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    case (state)
      GRANT0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_stall_o = s_stall_i;
        m0_ack_o   = s_ack_i;
      end
      GRANT1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_stall_o = s_stall_i;
        m1_ack_o   = s_ack_i;
      end
      default: ;  // IDLE: the slave is parked, and any stray ack is dropped
    endcase
  end

  // Read data goes to both masters. Only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
// Expected tie-break results follow the WB_ARB_ROUND_ROBIN_EN build setting.
module tb_wb_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]        m0_sel_i;
  logic [31:0]       m0_adr_i, m0_dat_i;
  logic              m0_stall_o, m0_ack_o;
  logic [31:0]       m0_dat_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]        m1_sel_i;
  logic [31:0]       m1_adr_i, m1_dat_i;
  logic              m1_stall_o, m1_ack_o;
  logic [31:0]       m1_dat_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic              s_stall_i, s_ack_i;
  logic [31:0]       s_dat_i;
  logic [1:0]        grant_o;

  int n_chk  = 0;
  int n_pass = 0;

  wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge. Checks run 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [1:0] tie_exp [4];
`ifdef WB_ARB_ROUND_ROBIN_EN
    tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    s_stall_i = 0; s_ack_i = 0; s_dat_i = 0;
    step(); step();
    rst_i = 1'b0;

    // Idle after reset. A stray slave ack must not reach either master.
    s_ack_i = 1'b1; s_dat_i = 32'h5555;
    #1;
    check("rst_s_cyc",    {31'd0, s_cyc_o},    32'd0);
    check("rst_s_stb",    {31'd0, s_stb_o},    32'd0);
    check("rst_m0_stall", {31'd0, m0_stall_o}, 32'd1);
    check("rst_m1_stall", {31'd0, m1_stall_o}, 32'd1);
    check("rst_grant",    {30'd0, grant_o},    32'd0);
    check("idle_ack_drop", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    s_ack_i = 1'b0;
    step();

    // m0 single write
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h100; m0_dat_i = 32'hDEADBEEF;
    #1;
    check("wr_grant_lat", {30'd0, grant_o}, 32'd0);
    check("wr_s_cyc_lat", {31'd0, s_cyc_o}, 32'd0);
    step();
    check("wr_grant", {30'd0, grant_o}, 32'd1);
    check("wr_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd7);
    check("wr_s_adr", s_adr_o, 32'h100);
    check("wr_s_dat", s_dat_o, 32'hDEADBEEF);
    check("wr_s_sel", {28'd0, s_sel_o}, 32'hF);
    check("wr_m0_stall", {31'd0, m0_stall_o}, 32'd0);
    check("wr_m1_stall", {31'd0, m1_stall_o}, 32'd1);
    step();
    m0_stb_i = 0; s_ack_i = 1;
    #1;
    check("wr_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    check("wr_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    step();
    m0_cyc_i = 0; m0_we_i = 0; s_ack_i = 0;
    step(); step();
    check("wr_idle", {30'd0, grant_o}, 32'd0);

    // Simultaneous requests from a fresh reset. The first round-robin tie goes to m0.
    rst_i = 1; step(); rst_i = 0;
    for (int r = 0; r < 4; r++) begin
      m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      check($sformatf("tie%0d_grant", r), {30'd0, grant_o}, {30'd0, tie_exp[r]});
      check($sformatf("tie%0d_loser_stall", r),
            {31'd0, (tie_exp[r] == 2'b01) ? m1_stall_o : m0_stall_o}, 32'd1);
      step(); step(); step();
      m0_cyc_i = 0; m1_cyc_i = 0;
      step(); step();
      check($sformatf("tie%0d_idle", r), {30'd0, grant_o}, 32'd0);
    end

    // m0 performs 3 pipelined reads with slave stalls while m1 waits.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0; s_stall_i = 1;
    step();
    m1_cyc_i = 1;
    #1;
    check("rd_grant", {30'd0, grant_o}, 32'd1);
    check("rd_m0_stall1", {31'd0, m0_stall_o}, 32'd1);
    step();
    s_stall_i = 0;
    step();
    m0_adr_i = 32'h4; s_stall_i = 1; s_ack_i = 1; s_dat_i = 32'h11;
    #1;
    check("rd_ack1", {31'd0, m0_ack_o}, 32'd1);
    check("rd_dat1", m0_dat_o, 32'h11);
    check("rd_m1_ack1", {31'd0, m1_ack_o}, 32'd0);
    check("rd_m1_stall1", {31'd0, m1_stall_o}, 32'd1);
    step();
    s_stall_i = 0; s_ack_i = 0;
    step();
    m0_adr_i = 32'h8; s_stall_i = 1; s_ack_i = 1; s_dat_i = 32'h22;
    #1;
    check("rd_ack2", {31'd0, m0_ack_o}, 32'd1);
    check("rd_dat2", m0_dat_o, 32'h22);
    step();
    s_stall_i = 0; s_ack_i = 0;
    step();
    m0_stb_i = 0; s_ack_i = 1; s_dat_i = 32'h33;
    #1;
    check("rd_ack3", {31'd0, m0_ack_o}, 32'd1);
    check("rd_dat3", m0_dat_o, 32'h33);
    check("rd_dat3_bcast", m1_dat_o, 32'h33);
    check("rd_m1_stall3", {31'd0, m1_stall_o}, 32'd1);
    step();
    m0_cyc_i = 0; s_ack_i = 0;
    #1;
    check("ho_s_cyc_low", {31'd0, s_cyc_o}, 32'd0);
    check("ho_grant_old", {30'd0, grant_o}, 32'd1);
    check("ho_m1_stall", {31'd0, m1_stall_o}, 32'd1);
    step();
    m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h200;
    #1;
    check("ho_grant_new", {30'd0, grant_o}, 32'd2);
    check("ho_s_cyc", {31'd0, s_cyc_o}, 32'd1);
    check("ho_m1_stall_rel", {31'd0, m1_stall_o}, 32'd0);
    check("ho_s_adr", s_adr_o, 32'h200);

    // Reset while m1 is mid-transfer, then a normal m0 request
    step();
    rst_i = 1;
    step();
    rst_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    #1;
    check("mrst_grant", {30'd0, grant_o}, 32'd0);
    check("mrst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("mrst_m1_stall", {31'd0, m1_stall_o}, 32'd1);
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    check("mrst_m0_grant", {30'd0, grant_o}, 32'd1);
    check("mrst_m0_s_cyc", {31'd0, s_cyc_o}, 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step(); step();

    // m1 pulses cyc for one idle cycle with stb low.
    m1_cyc_i = 1;
    step();
    m1_cyc_i = 0;
    #1;
    check("pulse_grant", {30'd0, grant_o}, 32'd2);
    check("pulse_s_stb", {31'd0, s_stb_o}, 32'd0);
    step();
    check("pulse_idle", {30'd0, grant_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
